// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller.
// Holds stage indices, the FSM state encoding and the default trap drain length.
// No logic; imported by pipe_hazard_ctrl and its watchdog.
package pipe_hazard_ctrl_pkg;

  // Stage indices of the 5-stage in-order core (bit 0 = youngest = PC/IF)
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // FSM encoding
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // Default number of unfrozen cycles older stages get to retire on trap entry
  localparam int DRAIN_CYC_DEF = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// Saturating stall watchdog counter.
// Ports: clk/rst_n; en_i counts up (saturating), clr_i clears (wins over en_i);
// sat_o is high while the registered count is all ones.
module pipe_hazard_ctrl_stall_watchdog
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WDT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [WDT_W-1:0] cnt_q;
  logic [WDT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WDT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded straight from the register, so no input-to-output path
  assign sat_o = (cnt_q == '1);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush, branch redirect, trap entry sequencing.
// Ports: stallreq_i per-stage hold requests; branch_i/branch_target_i and trap_i/trap_vec_i
// from the branch stage; stall_o/flush_o per stage; redirect_o/redirect_pc_o to PC unit;
// busy_o during trap entry; stall_timeout_o from the stall watchdog.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE    = 5,
  parameter int XLEN      = 32,
  parameter int BR_STAGE  = STG_EX,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int WDT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              branch_i,
  input  logic [XLEN-1:0]   branch_target_i,
  input  logic              trap_i,
  input  logic [XLEN-1:0]   trap_vec_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              busy_o,
  output logic              stall_timeout_o
);

  localparam int CW = $clog2(DRAIN_CYC + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC - 1);

  // Stages at/below the branch stage, strictly below it, and strictly above it
  localparam logic [NSTAGE-1:0] LOW_MASK  = NSTAGE'((1 << (BR_STAGE + 1)) - 1);
  localparam logic [NSTAGE-1:0] BEL_MASK  = NSTAGE'((1 << BR_STAGE) - 1);
  localparam logic [NSTAGE-1:0] HIGH_MASK = ~LOW_MASK;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   vec_q, vec_d;

  logic [NSTAGE-1:0] stall_c;
  logic [NSTAGE-1:0] flush_c;
  logic              stall_acc;
  logic              redirect_c;
  logic [XLEN-1:0]   redirect_pc_c;

  logic              in_run;
  logic              br_free;
  logic              trap_take;
  logic              br_take;
  logic              drain_frz;
  logic              any_stall;

  assign in_run    = (state_q == ST_RUN);
  assign br_free   = ~stall_c[BR_STAGE];
  // Trap has priority over a branch presented in the same cycle
  assign trap_take = in_run & br_free & trap_i;
  assign br_take   = in_run & br_free & branch_i & ~trap_i;
  assign drain_frz = |(stall_c & HIGH_MASK);
  assign any_stall = |stall_c;

  always_comb begin
    // A request at stage k holds k and everything younger: suffix-OR from the top
    stall_c   = '0;
    stall_acc = 1'b0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      stall_acc  = stall_acc | stallreq_i[j];
      stall_c[j] = stall_acc;
    end
    if (state_q == ST_DRAIN) begin
      stall_c = stall_c | LOW_MASK;
    end else if (state_q == ST_REDIRECT) begin
      stall_c = stall_c & ~LOW_MASK;
    end

    // Bubble into the first moving stage above a held one so the held
    // instruction is not also passed forward
    flush_c = '0;
    for (int k = 0; k < NSTAGE - 1; k++) begin
      flush_c[k+1] = stall_c[k] & ~stall_c[k+1];
    end

    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    if (trap_take) begin
      flush_c = flush_c | LOW_MASK;
    end else if (br_take) begin
      flush_c       = flush_c | BEL_MASK;
      redirect_c    = 1'b1;
      redirect_pc_c = branch_target_i;
    end else if (state_q == ST_REDIRECT) begin
      flush_c       = flush_c | LOW_MASK;
      redirect_c    = 1'b1;
      redirect_pc_c = vec_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    case (state_q)
      ST_RUN: begin
        if (trap_take) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
          vec_d   = trap_vec_i;
        end
      end
      ST_DRAIN: begin
        // Older stages still stalled: they have not retired, so do not spend a drain cycle
        if (!drain_frz) begin
          if (cnt_q == '0) begin
            state_d = ST_REDIRECT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_REDIRECT: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  // Watchdog only observes RUN; it holds across trap entry
  pipe_hazard_ctrl_stall_watchdog #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (in_run & any_stall),
    .clr_i (in_run & ~any_stall),
    .sat_o (stall_timeout_o)
  );

  // Combinational outputs are forced low while reset is asserted
  assign stall_o       = rst_n ? stall_c : '0;
  assign flush_o       = rst_n ? flush_c : '0;
  assign redirect_o    = rst_n & redirect_c;
  assign redirect_pc_o = rst_n ? redirect_pc_c : '0;
  assign busy_o        = rst_n & ~in_run;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int XL = 32;
  localparam int BR = 2;
  localparam int DC = 2;
  localparam int WW = 4;
  localparam int WMAX = (1 << WW) - 1;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_REDIR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] stallreq_i = '0;
  logic          branch_i = 1'b0;
  logic [XL-1:0] branch_target_i = '0;
  logic          trap_i = 1'b0;
  logic [XL-1:0] trap_vec_i = '0;
  logic [NS-1:0] stall_o;
  logic [NS-1:0] flush_o;
  logic          redirect_o;
  logic [XL-1:0] redirect_pc_o;
  logic          busy_o;
  logic          stall_timeout_o;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NSTAGE(NS), .XLEN(XL), .BR_STAGE(BR), .DRAIN_CYC(DC), .WDT_W(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stallreq_i(stallreq_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o), .stall_timeout_o(stall_timeout_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: mode, drain cycles still owed, captured vector, stall run length
  int            m_mode;
  int            m_left;
  logic [XL-1:0] m_vec;
  int            m_wdt;

  // Last observed outputs, for directed literal checks
  logic [NS-1:0] obs_stall, obs_flush;
  logic          obs_redir, obs_busy, obs_to;
  logic [XL-1:0] obs_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_left = 0;
    m_vec  = '0;
    m_wdt  = 0;
  endtask

  // One clock cycle: drive, check combinational outputs against the model, advance model
  task automatic cyc(input logic [NS-1:0] sr, input logic br, input logic [XL-1:0] tgt,
                     input logic tr, input logic [XL-1:0] vec);
    logic [NS-1:0] es, ef;
    logic          take_tr, take_br, e_red;
    logic [XL-1:0] e_pc;
    @(negedge clk);
    stallreq_i = sr; branch_i = br; branch_target_i = tgt; trap_i = tr; trap_vec_i = vec;
    #1;
    for (int j = 0; j < NS; j++) es[j] = ((sr >> j) != '0);
    if (m_mode == M_DRAIN) for (int j = 0; j <= BR; j++) es[j] = 1'b1;
    if (m_mode == M_REDIR) for (int j = 0; j <= BR; j++) es[j] = 1'b0;
    take_tr = (m_mode == M_RUN) && !es[BR] && tr;
    take_br = (m_mode == M_RUN) && !es[BR] && br && !tr;
    ef = '0;
    for (int k = 0; k < NS - 1; k++) ef[k+1] = es[k] && !es[k+1];
    if (take_tr || m_mode == M_REDIR) for (int j = 0; j <= BR; j++) ef[j] = 1'b1;
    if (take_br) for (int j = 0; j < BR; j++) ef[j] = 1'b1;
    e_red = take_br || (m_mode == M_REDIR);
    e_pc  = take_br ? tgt : (m_mode == M_REDIR) ? m_vec : '0;

    obs_stall = stall_o; obs_flush = flush_o; obs_redir = redirect_o;
    obs_pc = redirect_pc_o; obs_busy = busy_o; obs_to = stall_timeout_o;
    check("stall",    64'(stall_o),         64'(es));
    check("flush",    64'(flush_o),         64'(ef));
    check("redirect", 64'(redirect_o),      64'(e_red));
    check("pc",       64'(redirect_pc_o),   64'(e_pc));
    check("busy",     64'(busy_o),          64'(m_mode != M_RUN));
    check("timeout",  64'(stall_timeout_o), 64'(m_wdt == WMAX));

    @(posedge clk);
    case (m_mode)
      M_RUN: begin
        if (es != '0) m_wdt = (m_wdt < WMAX) ? m_wdt + 1 : WMAX;
        else          m_wdt = 0;
        if (take_tr) begin
          m_mode = M_DRAIN; m_left = DC; m_vec = vec;
        end
      end
      M_DRAIN: begin
        if ((es >> (BR + 1)) == '0) begin
          m_left--;
          if (m_left == 0) m_mode = M_REDIR;
        end
      end
      default: m_mode = M_RUN;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, '0, 1'b0, '0);
  endtask

  // Asynchronous reset, asserted between clock edges; outputs must drop at once
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stallreq_i = '1; branch_i = 1'b1; trap_i = 1'b1;
    branch_target_i = 32'hdead_beef; trap_vec_i = 32'hcafe_f00d;
    #1;
    check("rst_stall",    64'(stall_o),         64'(0));
    check("rst_flush",    64'(flush_o),         64'(0));
    check("rst_redirect", 64'(redirect_o),      64'(0));
    check("rst_pc",       64'(redirect_pc_o),   64'(0));
    check("rst_busy",     64'(busy_o),          64'(0));
    check("rst_timeout",  64'(stall_timeout_o), 64'(0));
    @(posedge clk);
    @(negedge clk);
    stallreq_i = '0; branch_i = 1'b0; trap_i = 1'b0;
    branch_target_i = '0; trap_vec_i = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [NS-1:0] sr;
    model_reset();
    do_reset();

    // Idle after reset
    idle(1);
    check("idle_stall", 64'(obs_stall), 64'(0));
    check("idle_busy",  64'(obs_busy),  64'(0));

    // Single EX stall request
    cyc(5'b00100, 1'b0, '0, 1'b0, '0);
    check("ex_stall", 64'(obs_stall), 64'(5'b00111));
    check("ex_flush", 64'(obs_flush), 64'(5'b01000));
    idle(1);

    // Taken branch, then the same branch while EX is held
    cyc('0, 1'b1, 32'h0000_0100, 1'b0, '0);
    check("br_redirect", 64'(obs_redir), 64'(1));
    check("br_pc",       64'(obs_pc),    64'(32'h100));
    check("br_flush",    64'(obs_flush), 64'(5'b00011));
    cyc(5'b00100, 1'b1, 32'h0000_0100, 1'b0, '0);
    check("br_stalled_redirect", 64'(obs_redir), 64'(0));
    idle(1);

    // Trap entry with no stalls
    cyc('0, 1'b0, '0, 1'b1, 32'h8000_0000);
    check("trap_flush", 64'(obs_flush), 64'(5'b00111));
    idle(1);
    check("drain1_busy",  64'(obs_busy),  64'(1));
    check("drain1_stall", 64'(obs_stall), 64'(5'b00111));
    idle(1);
    check("drain2_busy", 64'(obs_busy), 64'(1));
    idle(1);
    check("trap_redirect", 64'(obs_redir), 64'(1));
    check("trap_pc",       64'(obs_pc),    64'(32'h8000_0000));
    idle(1);
    check("trap_done_busy", 64'(obs_busy), 64'(0));

    // Trap entry with MEM stalled for three drain cycles
    cyc('0, 1'b0, '0, 1'b1, 32'h8000_0040);
    for (int i = 0; i < 3; i++) cyc(5'b01000, 1'b0, '0, 1'b0, '0);
    check("frz_no_redirect", 64'(obs_redir), 64'(0));
    idle(2);
    check("frz_still_drain", 64'(obs_busy), 64'(1));
    idle(1);
    check("frz_redirect", 64'(obs_redir), 64'(1));
    check("frz_pc",       64'(obs_pc),    64'(32'h8000_0040));
    idle(1);

    // Trap and branch together: trap wins
    cyc('0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_4000);
    check("both_redirect", 64'(obs_redir), 64'(0));
    check("both_flush",    64'(obs_flush), 64'(5'b00111));
    idle(2);
    idle(1);
    check("both_pc", 64'(obs_pc), 64'(32'h4000));
    idle(1);

    // Watchdog: ID held 15 cycles saturates the counter
    for (int i = 0; i < 15; i++) cyc(5'b00010, 1'b0, '0, 1'b0, '0);
    check("wdt_pre", 64'(obs_to), 64'(0));
    cyc(5'b00010, 1'b0, '0, 1'b0, '0);
    check("wdt_sat", 64'(obs_to), 64'(1));
    idle(1);
    idle(1);
    check("wdt_clear", 64'(obs_to), 64'(0));

    // Reset in the middle of trap drain
    cyc('0, 1'b0, '0, 1'b1, 32'h1234_5678);
    idle(1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("rst_drain_redirect", 64'(obs_redir), 64'(0));
      check("rst_drain_busy",     64'(obs_busy),  64'(0));
    end

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(249) == 0) begin
        do_reset();
      end else begin
        for (int b = 0; b < NS; b++) sr[b] = ($urandom_range(6) == 0);
        if ($urandom_range(9) == 0) sr = '0;
        cyc(sr, ($urandom_range(3) == 0), $urandom, ($urandom_range(11) == 0), $urandom);
      end
    end
    // Long single-stage stall to reach saturation under random PCs
    for (int i = 0; i < 20; i++) cyc(5'b10000, 1'b1, $urandom, 1'b1, $urandom);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
